// File: rtl/bip_result_uart_tx.sv
// Sends the BIP accumulator result as two 8N1 UART bytes (high byte first)
// on each rising edge of the processor halt flag.
`timescale 1ns/1ps
module bip_result_uart_tx #(
  parameter int DATA_LENGTH  = 16,
  parameter int NB_BYTE      = 8,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_halt,
  input  logic [DATA_LENGTH-1:0] i_data,
  output logic                   o_tx,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST = 3'(NB_BYTE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic                   byte_q, byte_d;
  logic                   tx_q, tx_d;
  logic                   done_q, done_d;
  logic                   halt_q;
  logic [DATA_LENGTH-1:0] data_q, data_d;
  logic [NB_BYTE-1:0]     cur_byte;
  logic                   bit_end;
  logic                   trigger;

  assign trigger  = i_halt & ~halt_q & (state_q == IDLE);
  assign bit_end  = (cnt_q == CNT_LAST);
  assign cur_byte = byte_q ? data_q[NB_BYTE-1:0] : data_q[DATA_LENGTH-1 -: NB_BYTE];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    data_d  = data_q;
    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (trigger) begin
          state_d = START;
          tx_d    = 1'b0;
          data_d  = i_data;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = 1'b0;
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
        tx_d    = cur_byte[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == BIT_LAST) begin
          state_d = STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = cur_byte[bit_q + 3'd1];
        end
      end
      STOP: if (bit_end) begin
        // The second start bit follows the first stop bit with no idle gap.
        if (!byte_q) begin
          state_d = START;
          byte_d  = 1'b1;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          byte_d  = 1'b0;
          done_d  = 1'b1;
          tx_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      halt_q  <= i_halt;
    end
  end

  // Captured word is only read while busy, so it needs no reset.
  always_ff @(posedge i_clock) begin
    data_q <= data_d;
  end

  assign o_tx   = tx_q;
  assign o_busy = (state_q != IDLE);
  assign o_done = done_q;

endmodule

// File: tb/tb_bip_result_uart_tx.sv
// Self-checking bench for bip_result_uart_tx with CLKS_PER_BIT=4.
`timescale 1ns/1ps
module tb_bip_result_uart_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic [15:0] data;
  logic        tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  bip_result_uart_tx #(.DATA_LENGTH(16), .NB_BYTE(8), .CLKS_PER_BIT(CPB)) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .i_halt (halt),
    .i_data (data),
    .o_tx   (tx),
    .o_busy (busy),
    .o_done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [7:0]  b0;
    logic [7:0]  b1;
    bit          chg;
    bit          tog;
  } vec_t;

  // Line waveform of one transmission, element 0 sent first.
  function automatic logic [19:0] frame_bits(input logic [7:0] b0, input logic [7:0] b1);
    logic [19:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1 + i] = b0[i];
    f[9]  = 1'b1;
    f[10] = 1'b0;
    for (int i = 0; i < 8; i++) f[11 + i] = b1[i];
    f[19] = 1'b1;
    return f;
  endfunction

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: tx/busy/done got %b expected %b", name, got, exp);
    end
  endtask

  task automatic launch(input logic [15:0] d);
    @(negedge clk);
    halt = 1'b0;
    data = d;
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
  endtask

  // Called right after trigger edge k; sample m is taken after edge k+m.
  task automatic check_frame(input logic [7:0] b0, input logic [7:0] b1, input bit chg,
                             input bit tog, input int last_m, input string tag);
    logic [19:0] f;
    logic [2:0]  exp;
    f = frame_bits(b0, b1);
    for (int m = 0; m <= last_m; m++) begin
      @(negedge clk);
      if (m < 20 * CPB)       exp = {f[m / CPB], 1'b1, 1'b0};
      else if (m == 20 * CPB) exp = 3'b101;
      else                    exp = 3'b100;
      check3($sformatf("%s m=%0d", tag, m), {tx, busy, done}, exp);
      if (chg && m == 0) data = 16'hFFFF;
      if (tog && m == 30) halt = 1'b0;
      if (tog && m == 31) halt = 1'b1;
    end
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0] rd;
    bit          rc, rt;

    vecs[0] = '{16'hA53C, 8'hA5, 8'h3C, 1'b1, 1'b1};
    vecs[1] = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[2] = '{16'hFFFF, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{16'h8001, 8'h80, 8'h01, 1'b0, 1'b1};

    rst_n = 1'b0;
    halt  = 1'b0;
    data  = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check3($sformatf("reset c%0d", i), {tx, busy, done}, 3'b100);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check3("idle after reset", {tx, busy, done}, 3'b100);

    for (int v = 0; v < 4; v++) begin
      launch(vecs[v].d);
      check_frame(vecs[v].b0, vecs[v].b1, vecs[v].chg, vecs[v].tog, 20 * CPB + 5,
                  $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      rd = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rt = 1'($urandom_range(0, 1));
      launch(rd);
      check_frame(rd[15:8], rd[7:0], rc, rt, 20 * CPB + 3, $sformatf("rnd%0d %h", r, rd));
    end

    launch(16'h1234);
    check_frame(8'h12, 8'h34, 1'b0, 1'b0, 45, "pre-abort");
    #2 rst_n = 1'b0;
    #1 check3("abort immediate", {tx, busy, done}, 3'b100);
    @(negedge clk);
    check3("abort held", {tx, busy, done}, 3'b100);
    data  = 16'hC35A;
    rst_n = 1'b1;
    @(posedge clk);
    check_frame(8'hC3, 8'h5A, 1'b0, 1'b0, 20 * CPB + 2, "post-abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
